// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP and returns one registered result.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [2:0]            req0_alu_op_i,
  input  logic [5:0]            req0_alu_function_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [2:0]            req1_alu_op_i,
  input  logic [5:0]            req1_alu_function_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic [2:0]            alu_op_o,
  output logic [5:0]            alu_function_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_id_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_id;
  logic [2:0]            r_op;
  logic [5:0]            r_fn;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_result_valid;
  logic                  r_result_id;

  logic w_any_valid;
  logic w_grant_idx;
  logic w_accept;
  logic w_in_exec;

  // Both valid: the one not granted last wins; otherwise the lone valid requester.
  assign w_any_valid = req0_valid_i | req1_valid_i;
  assign w_grant_idx = (req0_valid_i && req1_valid_i) ? ~r_last_grant : req1_valid_i;
  // Gated by reset so the ready pulses stay low while reset is asserted.
  assign w_accept    = (r_state == IDLE) && w_any_valid && !reset;
  assign w_in_exec   = (r_state == EXEC);

  assign req0_ready_o = w_accept && !w_grant_idx;
  assign req1_ready_o = w_accept &&  w_grant_idx;

  assign alu_op_o       = w_in_exec ? r_op : 3'b000;
  assign alu_function_o = w_in_exec ? r_fn : 6'b000000;
  assign alu_a_o        = w_in_exec ? r_a  : '0;
  assign alu_b_o        = w_in_exec ? r_b  : '0;

  assign result_valid_o = r_result_valid;
  assign result_o       = r_result;
  assign result_id_o    = r_result_id;
  assign busy_o         = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_result_id    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_last_grant <= w_grant_idx;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_result       <= alu_result_i;
          r_result_id    <= r_id;
          r_result_valid <= 1'b1;
          r_state        <= RESP;
        end
        RESP: begin
          if (result_ready_i) begin
            r_result_valid <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand capture happens only in the grant cycle; the in-flight op ignores later input changes.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_id <= w_grant_idx;
      r_op <= w_grant_idx ? req1_alu_op_i       : req0_alu_op_i;
      r_fn <= w_grant_idx ? req1_alu_function_i : req0_alu_function_i;
      r_a  <= w_grant_idx ? req1_a_i            : req0_a_i;
      r_b  <= w_grant_idx ? req1_b_i            : req0_b_i;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: the shared ALU is modelled as a plain adder of alu_a_o and alu_b_o.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [2:0]  req0_alu_op_i, req1_alu_op_i;
  logic [5:0]  req0_alu_function_i, req1_alu_function_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [2:0]  alu_op_o;
  logic [5:0]  alu_function_o;
  logic [31:0] alu_a_o, alu_b_o, alu_result_i;
  logic        result_valid_o, result_ready_i, result_id_o, busy_o;
  logic [31:0] result_o;

  int n_total = 0;
  int n_bad   = 0;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_alu_op_i(req0_alu_op_i), .req0_alu_function_i(req0_alu_function_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_alu_op_i(req1_alu_op_i), .req1_alu_function_i(req1_alu_function_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .alu_op_o(alu_op_o), .alu_function_o(alu_function_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_result_i(alu_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .result_id_o(result_id_o), .busy_o(busy_o)
  );

  assign alu_result_i = alu_a_o + alu_b_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid_i = 1'b1; req1_valid_i = 1'b1; result_ready_i = 1'b0;
    req0_alu_op_i = 3'd1; req0_alu_function_i = 6'd1; req0_a_i = 32'd1; req0_b_i = 32'd1;
    req1_alu_op_i = 3'd2; req1_alu_function_i = 6'd2; req1_a_i = 32'd2; req1_b_i = 32'd2;
    tick(); tick();
    #1;
    n_total++;
    if ({req0_ready_o, req1_ready_o, busy_o, result_valid_o, result_id_o} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {req0_ready_o, req1_ready_o, busy_o, result_valid_o, result_id_o});
    end
    n_total++;
    if ({result_o, alu_a_o, alu_b_o, alu_op_o, alu_function_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: result=%0h a=%0h b=%0h op=%0h fn=%0h want all 0",
               result_o, alu_a_o, alu_b_o, alu_op_o, alu_function_o);
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    req0_valid_i = 1'b1; req0_alu_op_i = 3'b100; req0_alu_function_i = 6'h21;
    req0_a_i = 32'd5; req0_b_i = 32'd7;
    #1;
    n_total++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
      n_bad++; $display("FAIL single_grant: ready=%b want 10", {req0_ready_o, req1_ready_o});
    end
    tick();
    req0_valid_i = 1'b0;
    #1;
    n_total++;
    if ({busy_o, alu_op_o, alu_function_o, alu_a_o, alu_b_o, req0_ready_o, result_valid_o}
        !== {1'b1, 3'b100, 6'h21, 32'd5, 32'd7, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL single_exec: busy=%b op=%b fn=%h a=%0d b=%0d rdy=%b rv=%b want 1 100 21 5 7 0 0",
               busy_o, alu_op_o, alu_function_o, alu_a_o, alu_b_o, req0_ready_o, result_valid_o);
    end
    tick();
    #1;
    n_total++;
    if ({result_valid_o, result_o, result_id_o, alu_a_o} !== {1'b1, 32'd12, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL single_result: rv=%b res=%0d id=%b alu_a=%0d want 1 12 0 0",
               result_valid_o, result_o, result_id_o, alu_a_o);
    end
    result_ready_i = 1'b1;
    tick();
    #1;
    n_total++;
    if ({busy_o, result_valid_o} !== 2'b00) begin
      n_bad++; $display("FAIL single_done: busy=%b rv=%b want 00", busy_o, result_valid_o);
    end
    result_ready_i = 1'b0;
  endtask

  task automatic test_contention();
    logic [31:0] exp_res;
    logic        exp_id;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    result_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_a_i = 32'd100; req0_b_i = 32'd1;
    req1_valid_i = 1'b1; req1_a_i = 32'd200; req1_b_i = 32'd2;
    for (int k = 0; k < 4; k++) begin
      exp_id  = k[0];
      exp_res = exp_id ? 32'd202 : 32'd101;
      #1;
      n_total++;
      if ({req0_ready_o, req1_ready_o} !== {~exp_id, exp_id}) begin
        n_bad++;
        $display("FAIL contention_grant%0d: ready=%b want %b", k,
                 {req0_ready_o, req1_ready_o}, {~exp_id, exp_id});
      end
      tick(); #1;
      n_total++;
      if ({req0_ready_o, req1_ready_o, alu_a_o} !== {2'b00, (exp_id ? 32'd200 : 32'd100)}) begin
        n_bad++;
        $display("FAIL contention_exec%0d: ready=%b a=%0d", k, {req0_ready_o, req1_ready_o}, alu_a_o);
      end
      tick(); #1;
      n_total++;
      if ({result_valid_o, result_o, result_id_o} !== {1'b1, exp_res, exp_id}) begin
        n_bad++;
        $display("FAIL contention_result%0d: rv=%b res=%0d id=%b want 1 %0d %b", k,
                 result_valid_o, result_o, result_id_o, exp_res, exp_id);
      end
      tick();
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; result_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    // Last grant before this test went to requester 1, so requester 0 wins here.
    req0_valid_i = 1'b1; req0_a_i = 32'd3; req0_b_i = 32'd4;
    req1_valid_i = 1'b1; req1_a_i = 32'd20; req1_b_i = 32'd3;
    #1;
    n_total++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
      n_bad++; $display("FAIL bp_grant: ready=%b want 10", {req0_ready_o, req1_ready_o});
    end
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if ({result_valid_o, result_o, result_id_o, req0_ready_o, req1_ready_o, busy_o}
          !== {1'b1, 32'd7, 1'b0, 2'b00, 1'b1}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: rv=%b res=%0d id=%b ready=%b busy=%b want 1 7 0 00 1", i,
                 result_valid_o, result_o, result_id_o, {req0_ready_o, req1_ready_o}, busy_o);
      end
      tick();
    end
    result_ready_i = 1'b1;
    tick(); #1;
    n_total++;
    if ({busy_o, result_valid_o, req0_ready_o, req1_ready_o} !== 4'b0001) begin
      n_bad++;
      $display("FAIL bp_release: busy=%b rv=%b ready=%b want 0 0 01",
               busy_o, result_valid_o, {req0_ready_o, req1_ready_o});
    end
    tick();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    #1;
    n_total++;
    if (alu_a_o !== 32'd20) begin
      n_bad++; $display("FAIL bp_next_exec: alu_a=%0d want 20", alu_a_o);
    end
    tick(); tick();
    result_ready_i = 1'b0;
  endtask

  task automatic test_operand_change();
    req1_valid_i = 1'b1; req1_alu_op_i = 3'b010; req1_alu_function_i = 6'h3f;
    req1_a_i = 32'd50; req1_b_i = 32'd3;
    #1;
    n_total++;
    if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
      n_bad++; $display("FAIL opchg_grant: ready=%b want 01", {req0_ready_o, req1_ready_o});
    end
    tick();
    req1_valid_i = 1'b0; req1_b_i = 32'd9; req1_alu_op_i = 3'b111; req1_alu_function_i = 6'h00;
    #1;
    n_total++;
    if ({alu_b_o, alu_op_o, alu_function_o} !== {32'd3, 3'b010, 6'h3f}) begin
      n_bad++;
      $display("FAIL opchg_exec: b=%0d op=%b fn=%h want 3 010 3f", alu_b_o, alu_op_o, alu_function_o);
    end
    tick(); #1;
    n_total++;
    if ({result_valid_o, result_o, result_id_o} !== {1'b1, 32'd53, 1'b1}) begin
      n_bad++;
      $display("FAIL opchg_result: rv=%b res=%0d id=%b want 1 53 1", result_valid_o, result_o, result_id_o);
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    req0_valid_i = 1'b1; req0_a_i = 32'd8; req0_b_i = 32'd8;
    tick();
    req0_valid_i = 1'b0;
    #1;
    n_total++;
    if ({busy_o, alu_a_o} !== {1'b1, 32'd8}) begin
      n_bad++; $display("FAIL rst_pre: busy=%b a=%0d want 1 8", busy_o, alu_a_o);
    end
    reset = 1'b1;
    #1;
    n_total++;
    if ({busy_o, alu_a_o, alu_b_o, result_valid_o, result_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_async: busy=%b a=%0d b=%0d rv=%b res=%0d want all 0",
               busy_o, alu_a_o, alu_b_o, result_valid_o, result_o);
    end
    tick();
    reset = 1'b0;
    tick(); tick(); #1;
    n_total++;
    if ({busy_o, result_valid_o} !== 2'b00) begin
      n_bad++; $display("FAIL rst_after: busy=%b rv=%b want 00", busy_o, result_valid_o);
    end
    req0_valid_i = 1'b1; req1_valid_i = 1'b1; result_ready_i = 1'b1;
    #1;
    n_total++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
      n_bad++; $display("FAIL rst_regrant: ready=%b want 10", {req0_ready_o, req1_ready_o});
    end
    tick();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick(); #1;
    n_total++;
    if ({result_valid_o, result_id_o, result_o} !== {1'b1, 1'b0, 32'd16}) begin
      n_bad++;
      $display("FAIL rst_result: rv=%b id=%b res=%0d want 1 0 16", result_valid_o, result_id_o, result_o);
    end
    tick();
    result_ready_i = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      result_ready_i = i[0];
      #1;
      n_total++;
      if ({busy_o, req0_ready_o, req1_ready_o, result_valid_o, alu_op_o, alu_function_o, alu_a_o, alu_b_o}
          !== '0) begin
        n_bad++;
        $display("FAIL idle%0d: busy=%b ready=%b rv=%b op=%b fn=%h a=%0d b=%0d want all 0", i,
                 busy_o, {req0_ready_o, req1_ready_o}, result_valid_o, alu_op_o, alu_function_o,
                 alu_a_o, alu_b_o);
      end
      tick();
    end
    result_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_operand_change();
    test_reset_mid_exec();
    test_idle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand and result width.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid_i  input  1  requester 0 has an operation pending.
REQ-005 req0_ready_o  output  1  one-cycle pulse: requester 0 operation accepted this cycle.
REQ-006 req0_alu_op_i, req0_alu_function_i, req0_a_i, req0_b_i  input  3/6/DATA_WIDTH/DATA_WIDTH  requester 0 ALU op code, function field, operands.
REQ-007 req1_valid_i, req1_ready_o, req1_alu_op_i, req1_alu_function_i, req1_a_i, req1_b_i  same widths and meanings for requester 1.
REQ-008 alu_op_o  output  3  ALU op code driven to the shared ALU control.
REQ-009 alu_function_o  output  6  function field driven to the shared ALU control.
REQ-010 alu_a_o, alu_b_o  output  DATA_WIDTH  operands driven to the shared ALU.
REQ-011 alu_result_i  input  DATA_WIDTH  combinational result from the shared ALU.
REQ-012 result_valid_o  output  1  result_o/result_id_o hold a completed result.
REQ-013 result_ready_i  input  1  consumer accepts the result this cycle.
REQ-014 result_o  output  DATA_WIDTH  registered ALU result.
REQ-015 result_id_o  output  1  requester index that owns result_o.
REQ-016 busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; exactly one active per cycle.
REQ-018 IDLE: if no reqN_valid_i, stay IDLE, all ready outputs 0.
REQ-019 IDLE with valid requests: grant per REQ-020, pulse the granted reqN_ready_o for that cycle only, latch its op/function/a/b and index, go to EXEC.
REQ-020 Arbitration round-robin: single requester valid wins; both valid, the requester not granted last wins; last-grant register updates on every grant.
REQ-021 EXEC: drive alu_*_o from latched fields for the whole cycle; at the cycle's end capture alu_result_i into result_o, set result_valid_o, go to RESP.
REQ-022 Outside EXEC: alu_op_o = 3'b000, alu_function_o = 6'b000000, alu_a_o = alu_b_o = 0.
REQ-023 RESP: hold result_o, result_id_o, result_valid_o stable until result_ready_i sampled high; that cycle clear result_valid_o and return to IDLE.
REQ-024 No new grant in EXEC or RESP; both ready outputs 0 there regardless of valid inputs.
REQ-025 Latency: accept in cycle N -> result_valid_o high from cycle N+2; max throughput one op per 3 cycles with result_ready_i tied high.
REQ-026 Requester inputs are sampled only in the grant cycle; later changes do not affect the in-flight operation.
REQ-027 result_ready_i while result_valid_o is low is ignored.
REQ-028 Requester withdrawing valid before grant is never granted; no state change.
REQ-029 Op codes and function fields pass through unmodified; arbiter does no decoding.

Reset
REQ-030 Reset asserted at any time, including mid-EXEC or RESP: state IDLE, result_valid_o 0, result_o 0, result_id_o 0, busy_o 0, ready outputs 0, ALU drive outputs 0, in-flight operation discarded.
REQ-031 Last-grant register resets to requester 1, so requester 0 wins the first simultaneous request.
REQ-032 First grant possible on the first rising edge after reset deasserts.

Verification
REQ-033 Single op: req0 valid, op 3'b100, a=5, b=7, alu model adds -> req0_ready_o pulse cycle N, alu_a_o=5/alu_b_o=7 in N+1, result_valid_o=1 with result_o=12, result_id_o=0 in N+2.
REQ-034 Contention: both valid continuously after reset, result_ready_i=1 -> grant order 0,1,0,1; each result_id_o matches grant; one result every 3 cycles.
REQ-035 Backpressure: result_ready_i=0 for 5 cycles in RESP -> result_o stable, no ready pulses, req held; release -> IDLE next cycle, next grant the cycle after.
REQ-036 Operand change: req1 changes b from 3 to 9 after its ready pulse -> result computed with b=3.
REQ-037 Reset mid-EXEC: reset asserted during EXEC -> outputs zero immediately (asynchronous), no result_valid_o after release, next simultaneous request grants requester 0.
REQ-038 Idle check: no valid inputs for 10 cycles -> busy_o 0, ALU drive outputs 0, ready outputs 0 throughout.
